branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters, serving the fetch-stage prediction ports and trained from the execute stage. Lookup is combinational on PCF in the same cycle; allocation and training happen on the clock edge from execute-stage branch results. It sits beside the PC register and fetch mux. It supplies PredictedPCF/EntryFoundF/Predicted_Taken_F to the datapath and consumes its BTBWriteE/BranchE/PCSrcE/EntryFoundE/PCE/PCBranchE outputs.

## Interface
- ENTRIES, 16: number of entries; power of two, ≥2.
- INDEX_BITS, 4: log2(ENTRIES).
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears the table.
- InvalidateAll  input  1  synchronous clear of all entries, same effect as reset.
- PCF  input  32  fetch PC for lookup.
- PredictedPCF  output  32  stored target on hit; PCF+4 on miss.
- EntryFoundF  output  1  valid entry with matching tag at PCF's index.
- Predicted_Taken_F  output  1  EntryFoundF & counter[1].
- StallE  input  1  execute stage held; suppresses all updates.
- BranchE  input  1  instruction in E is a conditional branch.
- PCSrcE  input  1  resolved outcome in E: 1 = taken.
- EntryFoundE  input  1  the E branch hit in the BTB at fetch.
- BTBWriteE  input  1  allocate request (taken & not found).
- PCE  input  32  PC of the E instruction.
- PCBranchE  input  32  resolved branch target of the E instruction.

## Operation
- Entry fields: valid (1), tag (32−INDEX_BITS−2), target (32), ctr (2).
- Index = PC[INDEX_BITS+1:2]; tag = PC[31:INDEX_BITS+2]; PC[1:0] ignored.
- Lookup (combinational): hitF = valid[idx(PCF)] & tag match. PredictedPCF = hitF ? target : PCF+4, with 32-bit wrap, so 32'hFFFFFFFC+4 = 0.
- Update enable: upd = ~StallE & ~reset & ~InvalidateAll.
- Allocate (upd & BTBWriteE): write entry at idx(PCE) with valid=1, tag(PCE), target=PCBranchE, ctr=2'b10. Unconditionally replaces any resident entry (conflict eviction).
- Train (upd & BranchE & EntryFoundE & ~BTBWriteE): acts only if the entry at idx(PCE) is still valid with tag(PCE); otherwise no write (entry was evicted since fetch).
  - On PCSrcE=1: ctr saturating +1 (max 2'b11), target←PCBranchE.
  - On PCSrcE=0: ctr saturating −1 (min 2'b00); target unchanged.
- Not-found, not-taken branch: no write. Non-branch (BranchE=0, BTBWriteE=0): no write.
- BTBWriteE and train are mutually exclusive by construction. If both arrive anyway, allocate wins.
- Entries with ctr=00/01 stay valid; they report EntryFoundF=1, Predicted_Taken_F=0.

## Timing
- Lookup latency 0: outputs follow PCF combinationally from current table state.
- Update visible to lookup the cycle after the edge it is written on. There is no same-cycle bypass: a lookup of the index being written that cycle returns pre-edge contents.
- StallE held N cycles: exactly one update, on the first edge with StallE=0.
- reset or InvalidateAll at an edge: all valid←0, ctr←00, target←0, tag←0. Any same-cycle update is dropped. Both take effect mid-stream regardless of StallE.
- Outputs after reset: EntryFoundF=0, Predicted_Taken_F=0, PredictedPCF=PCF+4.
- Single write port; at most one entry modified per cycle.

## Test plan
- Reset/miss: assert reset 1 cycle, PCF=0x00400010 -> EntryFoundF=0, Predicted_Taken_F=0, PredictedPCF=0x00400014.
- Allocate: BTBWriteE=1, PCE=0x00400010, PCBranchE=0x00400100. Next cycle PCF=0x00400010 -> EntryFoundF=1, Predicted_Taken_F=1, PredictedPCF=0x00400100. During the write cycle itself, the same lookup still misses.
- Saturation: from ctr=10, three trains taken -> ctr=11, Predicted_Taken_F=1. Then two not-taken -> 01, Predicted_Taken_F=0, EntryFoundF=1. Three more not-taken -> stays 00.
- Conflict: allocate PCE=0x00400010, then allocate PCE=0x00400050 (same index, 16 entries). Lookup 0x00400010 -> miss. A train with EntryFoundE=1, PCE=0x00400010 -> entry for 0x00400050 unchanged.
- Stall: BTBWriteE=1 with StallE=1 for 3 cycles, then StallE=0 -> entry written once, at the release edge only. Train held under stall -> counter moves by exactly 1.
- InvalidateAll with simultaneous BTBWriteE -> all lookups miss next cycle. Wrap check: PCF=0xFFFFFFFC on a miss -> PredictedPCF=0x00000000.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Fetch-side lookup is combinational; allocation and training come from execute.
module branch_target_buffer #(
    parameter int ENTRIES    = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        InvalidateAll,
    input  logic [31:0] PCF,
    output logic [31:0] PredictedPCF,
    output logic        EntryFoundF,
    output logic        Predicted_Taken_F,
    input  logic        StallE,
    input  logic        BranchE,
    input  logic        PCSrcE,
    input  logic        EntryFoundE,
    input  logic        BTBWriteE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCBranchE
);

    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    logic                validArr  [ENTRIES];
    logic [TAG_BITS-1:0] tagArr    [ENTRIES];
    logic [31:0]         targetArr [ENTRIES];
    logic [1:0]          ctrArr    [ENTRIES];

    logic [INDEX_BITS-1:0] idxF;
    logic [INDEX_BITS-1:0] idxE;
    logic [TAG_BITS-1:0]   tagF;
    logic [TAG_BITS-1:0]   tagE;
    logic                  hitF;
    logic                  residentE;
    logic                  updateEn;
    logic                  doAllocate;
    logic                  doTrain;
    logic [1:0]            ctrNext;
    logic                  unusedPcBits;

    assign idxF = PCF[INDEX_BITS+1:2];
    assign tagF = PCF[31:INDEX_BITS+2];
    assign idxE = PCE[INDEX_BITS+1:2];
    assign tagE = PCE[31:INDEX_BITS+2];

    // Byte offset bits never participate in indexing or tag matching.
    assign unusedPcBits = ^{PCF[1:0], PCE[1:0]};

    assign hitF              = validArr[idxF] && (tagArr[idxF] == tagF);
    assign EntryFoundF       = hitF;
    assign Predicted_Taken_F = hitF && ctrArr[idxF][1];
    assign PredictedPCF      = hitF ? targetArr[idxF] : PCF + 32'd4;

    // Training only touches the entry if it still belongs to this branch.
    assign residentE  = validArr[idxE] && (tagArr[idxE] == tagE);
    assign updateEn   = !StallE;
    assign doAllocate = updateEn && BTBWriteE;
    assign doTrain    = updateEn && BranchE && EntryFoundE && !BTBWriteE && residentE;

    always_comb begin
        ctrNext = ctrArr[idxE];
        if (PCSrcE) begin
            if (ctrArr[idxE] != 2'b11) ctrNext = ctrArr[idxE] + 2'd1;
        end else begin
            if (ctrArr[idxE] != 2'b00) ctrNext = ctrArr[idxE] - 2'd1;
        end
    end

    // Clear has priority over any update arriving in the same cycle, stalled or not.
    always_ff @(posedge clk) begin
        if (reset || InvalidateAll) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validArr[i]  <= 1'b0;
                tagArr[i]    <= '0;
                targetArr[i] <= '0;
                ctrArr[i]    <= 2'b00;
            end
        end else if (doAllocate) begin
            validArr[idxE]  <= 1'b1;
            tagArr[idxE]    <= tagE;
            targetArr[idxE] <= PCBranchE;
            ctrArr[idxE]    <= 2'b10;
        end else if (doTrain) begin
            ctrArr[idxE] <= ctrNext;
            if (PCSrcE) targetArr[idxE] <= PCBranchE;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: lookup, allocation, counter training,
// conflict eviction, stall hold, invalidate and PC wrap.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        InvalidateAll;
    logic [31:0] PCF;
    logic [31:0] PredictedPCF;
    logic        EntryFoundF;
    logic        Predicted_Taken_F;
    logic        StallE;
    logic        BranchE;
    logic        PCSrcE;
    logic        EntryFoundE;
    logic        BTBWriteE;
    logic [31:0] PCE;
    logic [31:0] PCBranchE;

    int checkCount = 0;
    int failCount  = 0;

    branch_target_buffer #(.ENTRIES(16), .INDEX_BITS(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .InvalidateAll    (InvalidateAll),
        .PCF              (PCF),
        .PredictedPCF     (PredictedPCF),
        .EntryFoundF      (EntryFoundF),
        .Predicted_Taken_F(Predicted_Taken_F),
        .StallE           (StallE),
        .BranchE          (BranchE),
        .PCSrcE           (PCSrcE),
        .EntryFoundE      (EntryFoundE),
        .BTBWriteE        (BTBWriteE),
        .PCE              (PCE),
        .PCBranchE        (PCBranchE)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        reset         = 1'b0;
        InvalidateAll = 1'b0;
        StallE        = 1'b0;
        BranchE       = 1'b0;
        PCSrcE        = 1'b0;
        EntryFoundE   = 1'b0;
        BTBWriteE     = 1'b0;
        PCE           = 32'h0;
        PCBranchE     = 32'h0;
    endtask

    task automatic applyStimulus(input logic branch, input logic taken, input logic found,
                                 input logic write, input logic stall,
                                 input logic [31:0] pc, input logic [31:0] target);
        BranchE     = branch;
        PCSrcE      = taken;
        EntryFoundE = found;
        BTBWriteE   = write;
        StallE      = stall;
        PCE         = pc;
        PCBranchE   = target;
    endtask

    // Inputs change 1ns after the rising edge so checks sit well inside the cycle.
    task automatic tick(input logic keep);
        @(posedge clk);
        #1;
        if (!keep) idleInputs();
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic expFound,
                          input logic expTaken, input logic [31:0] expPc);
        PCF = pc;
        #1;
        checkOutput({tag, ".found"}, {31'd0, EntryFoundF}, {31'd0, expFound});
        checkOutput({tag, ".taken"}, {31'd0, Predicted_Taken_F}, {31'd0, expTaken});
        checkOutput({tag, ".pc"}, PredictedPCF, expPc);
    endtask

    task automatic train(input logic taken, input logic [31:0] pc, input logic [31:0] target);
        applyStimulus(1'b1, taken, 1'b1, 1'b0, 1'b0, pc, target);
        tick(1'b0);
    endtask

    task automatic allocate(input logic [31:0] pc, input logic [31:0] target);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, pc, target);
        tick(1'b0);
    endtask

    task automatic invalidate();
        InvalidateAll = 1'b1;
        tick(1'b0);
    endtask

    initial begin
        idleInputs();
        PCF   = 32'h0040_0010;
        reset = 1'b1;
        tick(1'b0);
        lookup("reset", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);

        // Allocation is not visible until after its write edge.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0010, 32'h0040_0100);
        lookup("allocSameCycle", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
        tick(1'b0);
        lookup("allocHit", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);

        // 10 -> 11 -> 11 -> 11
        for (int i = 0; i < 3; i++) train(1'b1, 32'h0040_0010, 32'h0040_0100);
        lookup("satHigh", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
        // 11 -> 10, target untouched on not-taken
        train(1'b0, 32'h0040_0010, 32'h0040_0300);
        lookup("down1", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
        // 10 -> 01: still found, predicted not taken
        train(1'b0, 32'h0040_0010, 32'h0040_0300);
        lookup("down2", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100);
        // 01 -> 00 -> 00 -> 00
        for (int i = 0; i < 3; i++) train(1'b0, 32'h0040_0010, 32'h0040_0300);
        lookup("satLow", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100);
        // 00 -> 01 still not taken; target follows taken outcome
        train(1'b1, 32'h0040_0010, 32'h0040_0200);
        lookup("up1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0200);
        train(1'b1, 32'h0040_0010, 32'h0040_0200);
        lookup("up2", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);

        // Conflict eviction: 0x...50 shares index 4 with 0x...10
        invalidate();
        allocate(32'h0040_0010, 32'h0040_0100);
        allocate(32'h0040_0050, 32'h0040_0500);
        lookup("evicted", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
        lookup("resident", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0500);
        train(1'b1, 32'h0040_0010, 32'h0040_0888);
        train(1'b0, 32'h0040_0010, 32'h0040_0888);
        train(1'b0, 32'h0040_0010, 32'h0040_0888);
        lookup("staleTrain", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0500);

        // Allocation held under stall lands only at the release edge
        invalidate();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0040_0020, 32'h0040_0400);
        for (int i = 0; i < 3; i++) tick(1'b1);
        lookup("stallAlloc", 32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024);
        StallE = 1'b0;
        tick(1'b0);
        lookup("releaseAlloc", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0400);

        // Not-taken train held 3 cycles moves the counter once: 10 -> 01
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0020, 32'h0040_0400);
        for (int i = 0; i < 3; i++) tick(1'b1);
        lookup("stallTrain", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0400);
        StallE = 1'b0;
        tick(1'b0);
        lookup("releaseTrain", 32'h0040_0020, 1'b1, 1'b0, 32'h0040_0400);
        train(1'b1, 32'h0040_0020, 32'h0040_0400);
        lookup("onceOnly", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0400);

        // Not-found, not-taken branch allocates nothing
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0030, 32'h0040_0700);
        tick(1'b0);
        lookup("noAllocNT", 32'h0040_0030, 1'b0, 1'b0, 32'h0040_0034);

        // InvalidateAll beats a same-cycle allocation
        InvalidateAll = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0040, 32'h0040_0444);
        tick(1'b0);
        lookup("invOld", 32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024);
        lookup("invNew", 32'h0040_0040, 1'b0, 1'b0, 32'h0040_0044);

        // Reset clears even while execute is stalled
        allocate(32'h0040_0060, 32'h0040_0600);
        lookup("preReset", 32'h0040_0060, 1'b1, 1'b1, 32'h0040_0600);
        reset  = 1'b1;
        StallE = 1'b1;
        tick(1'b0);
        lookup("resetStall", 32'h0040_0060, 1'b0, 1'b0, 32'h0040_0064);

        lookup("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
